// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store with fixed wait states.
// Optional ARB_PERF_EN adds saturating per-port stall counters with a synchronous clear.
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
`ifdef ARB_PERF_EN
  input  logic          perf_clr,
  output logic [31:0]   if_stall_cnt,
  output logic [31:0]   dm_stall_cnt,
`endif
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DACC = 2'd1;
  localparam logic [1:0] S_IACC = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          pick_d, pick_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  // On completion the other port wins, so each requester waits at most one foreign access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    pick_d  = 1'b0;
    pick_i  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pick_d = dm_req;
        pick_i = if_req & ~dm_req;
      end
      S_DACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pick_i  = if_req;
          pick_d  = dm_req & ~if_req;
          state_d = S_IDLE;
        end
      end
      S_IACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pick_d  = dm_req;
          pick_i  = if_req & ~dm_req;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pick_d) begin
      state_d = S_DACC;
      cnt_d   = CNT_INIT;
      addr_d  = dm_addr;
      wdata_d = dm_wdata;
      we_d    = dm_we;
    end else if (pick_i) begin
      state_d = S_IACC;
      cnt_d   = CNT_INIT;
      addr_d  = if_addr;
      we_d    = 1'b0;
    end
  end

  // Completion outputs are valid only in the final access cycle.
  assign dm_ack    = (state_q == S_DACC) && (cnt_q == 4'd0);
  assign if_ack    = (state_q == S_IACC) && (cnt_q == 4'd0);
  assign mem_en    = (state_q == S_DACC) || (state_q == S_IACC);
  assign mem_we    = dm_ack & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_ack ? mem_rdata : '0;
  assign dm_rdata  = dm_ack ? mem_rdata : '0;
  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_req & ~dm_ack;

`ifdef ARB_PERF_EN
  logic [31:0] if_cnt_q, dm_cnt_q;

  // Saturating stall counters; clear takes precedence over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_cnt_q <= 32'd0;
      dm_cnt_q <= 32'd0;
    end else if (perf_clr) begin
      if_cnt_q <= 32'd0;
      dm_cnt_q <= 32'd0;
    end else begin
      if (if_stall && (if_cnt_q != 32'hFFFF_FFFF)) if_cnt_q <= if_cnt_q + 32'd1;
      if (dm_stall && (dm_cnt_q != 32'hFFFF_FFFF)) dm_cnt_q <= dm_cnt_q + 32'd1;
    end
  end

  assign if_stall_cnt = if_cnt_q;
  assign dm_stall_cnt = dm_cnt_q;
`else
  // No stall counters in this build.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, arbitration/reset sequences, and random
// traffic against a transaction-level model; stall counters are checked when ARB_PERF_EN is set.
module tb_mem_port_arbiter;

  localparam int unsigned W = 2;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic en; logic we; logic [31:0] ma; logic [31:0] md;
    logic iack; logic [31:0] ird; logic dack; logic [31:0] drd;
    logic ist; logic dst;
  } exp_t;

  typedef struct {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we;
`ifdef ARB_PERF_EN
  logic perf_clr;
  logic [31:0] if_stall_cnt, dm_stall_cnt;
  int unsigned m_pi, m_pd;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem  [64];
  logic [31:0] mmem [64];
  logic mem_init;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_STATES(W), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
`ifdef ARB_PERF_EN
    .perf_clr(perf_clr), .if_stall_cnt(if_stall_cnt), .dm_stall_cnt(dm_stall_cnt),
`endif
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'h2008_0005 : 32'hA5A5_0000 + 32'(i);
  endfunction

  // Simple synchronous-write, combinational-read memory.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, ".mem_en"},    32'(mem_en),   32'(e.en));
    chk({tag, ".mem_we"},    32'(mem_we),   32'(e.we));
    chk({tag, ".mem_addr"},  mem_addr,      e.ma);
    chk({tag, ".mem_wdata"}, mem_wdata,     e.md);
    chk({tag, ".if_ack"},    32'(if_ack),   32'(e.iack));
    chk({tag, ".if_rdata"},  if_rdata,      e.ird);
    chk({tag, ".dm_ack"},    32'(dm_ack),   32'(e.dack));
    chk({tag, ".dm_rdata"},  dm_rdata,      e.drd);
    chk({tag, ".if_stall"},  32'(if_stall), 32'(e.ist));
    chk({tag, ".dm_stall"},  32'(dm_stall), 32'(e.dst));
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  // Transaction-level reference: who owns the memory, which cycle its access completes, what it latched.
  logic        m_busy, m_own_i, m_we;
  logic [31:0] m_addr, m_wdata;
  int unsigned cyc, m_done;

  initial begin
    vec_t tbl [21];
    exp_t e;
    logic [31:0] P, M0, M4, M17, DB;
    logic d_act, i_act, fin, pref_i, gi, gd;
    int last_t, last_port, nack, port, ack_at;

    P = 32'h2008_0005; M0 = 32'hA5A5_0000; M4 = 32'hA5A5_0004; M17 = 32'hA5A5_0011; DB = 32'hDEAD_BEEF;
    tbl[0]  = '{H, 32'h40, L, L, 32'h0, 32'h0, '{L, L, 32'h0, 32'h0, L, 32'h0, L, 32'h0, H, L}};
    tbl[1]  = '{H, 32'h40, L, L, 32'h0, 32'h0, '{H, L, 32'h40, 32'h0, L, 32'h0, L, 32'h0, H, L}};
    tbl[2]  = tbl[1];
    tbl[3]  = '{L, 32'h40, L, L, 32'h0, 32'h0, '{H, L, 32'h40, 32'h0, H, P, L, 32'h0, L, L}};
    tbl[4]  = '{L, 32'h0, L, L, 32'h0, 32'h0, '{L, L, 32'h40, 32'h0, L, 32'h0, L, 32'h0, L, L}};
    tbl[5]  = '{H, 32'h44, H, L, 32'h100, 32'h0, '{L, L, 32'h40, 32'h0, L, 32'h0, L, 32'h0, H, H}};
    tbl[6]  = '{H, 32'h44, H, L, 32'h100, 32'h0, '{H, L, 32'h100, 32'h0, L, 32'h0, L, 32'h0, H, H}};
    tbl[7]  = tbl[6];
    tbl[8]  = '{H, 32'h44, H, L, 32'h100, 32'h0, '{H, L, 32'h100, 32'h0, L, 32'h0, H, M0, H, L}};
    tbl[9]  = '{H, 32'h44, L, L, 32'h0, 32'h0, '{H, L, 32'h44, 32'h0, L, 32'h0, L, 32'h0, H, L}};
    tbl[10] = tbl[9];
    tbl[11] = '{L, 32'h44, L, L, 32'h0, 32'h0, '{H, L, 32'h44, 32'h0, H, M17, L, 32'h0, L, L}};
    tbl[12] = '{L, 32'h0, L, L, 32'h0, 32'h0, '{L, L, 32'h44, 32'h0, L, 32'h0, L, 32'h0, L, L}};
    tbl[13] = '{L, 32'h0, H, H, 32'h10, DB, '{L, L, 32'h44, 32'h0, L, 32'h0, L, 32'h0, L, H}};
    tbl[14] = '{L, 32'h0, H, H, 32'h10, DB, '{H, L, 32'h10, DB, L, 32'h0, L, 32'h0, L, H}};
    tbl[15] = tbl[14];
    tbl[16] = '{L, 32'h0, H, L, 32'h10, DB, '{H, H, 32'h10, DB, L, 32'h0, H, M4, L, L}};
    tbl[17] = '{L, 32'h0, H, L, 32'h10, DB, '{H, L, 32'h10, DB, L, 32'h0, L, 32'h0, L, H}};
    tbl[18] = tbl[17];
    tbl[19] = '{L, 32'h0, L, L, 32'h10, DB, '{H, L, 32'h10, DB, L, 32'h0, H, DB, L, L}};
    tbl[20] = '{L, 32'h0, L, L, 32'h0, 32'h0, '{L, L, 32'h10, DB, L, 32'h0, L, 32'h0, L, L}};

    drive(L, 32'h0, L, L, 32'h0, 32'h0);
`ifdef ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    reset = 1'b0; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1; mem_init = 1'b0;

    // Directed table: fetch, dual request, store then same-port load.
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      @(negedge clk);
      chk_out($sformatf("tbl%0d", i), tbl[i].e);
    end

    // Continuous dual requests: grants must alternate, one ack every W+1 cycles.
    @(posedge clk); #1;
    drive(H, 32'h80, H, L, 32'h84, 32'h0);
    last_t = -1; last_port = -1; nack = 0;
    for (int t = 0; t < 24; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (if_ack || dm_ack) begin
        port = if_ack ? 1 : 0;
        chk("fair.dual_ack", 32'(if_ack & dm_ack), 32'd0);
        if (nack == 0) begin
          chk("fair.first_port", 32'(port), 32'd0);
          chk("fair.first_time", 32'(t), 32'(W + 1));
        end else begin
          chk("fair.alternate", 32'(port), 32'(1 - last_port));
          chk("fair.gap", 32'(t - last_t), 32'(W + 1));
        end
        last_t = t; last_port = port; nack++;
      end
    end
    chk("fair.ack_count", 32'(nack), 32'(23 / (W + 1)));
    @(posedge clk); #1;
    drive(L, 32'h0, L, L, 32'h0, 32'h0);
    repeat (2 * (W + 1) + 1) @(posedge clk);

    // Reset in the middle of a store: outputs clear at once and the write never happens.
    @(posedge clk); #1;
    drive(L, 32'h0, H, H, 32'h20, 32'h1234_5678);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0; #1;
    chk_out("rst.async", '{L, L, 32'h0, 32'h0, L, 32'h0, L, 32'h0, L, H});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst.no_we", 32'(mem_we), 32'd0);
    end
    drive(L, 32'h0, L, L, 32'h0, 32'h0);
    chk("rst.mem_untouched", mem[8], init_val(8));
    @(posedge clk); #1;
    reset = 1'b1;
    drive(H, 32'h44, L, L, 32'h0, 32'h0);
    ack_at = 99;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_ack && ack_at == 99) begin
        ack_at = k;
        chk("rst.fetch_rdata", if_rdata, init_val(17));
        if_req = 1'b0;
      end
    end
    chk("rst.fetch_latency", 32'(ack_at), 32'(W + 1));

    // Random traffic from compliant requesters, compared cycle by cycle with the model.
    @(negedge clk); reset = 1'b0; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1; mem_init = 1'b0;
    for (int i = 0; i < 64; i++) mmem[i] = init_val(i);
    m_busy = 1'b0; m_own_i = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
    cyc = 0; m_done = 0; d_act = 1'b0; i_act = 1'b0;
`ifdef ARB_PERF_EN
    m_pi = 0; m_pd = 0;
`endif
    for (int t = 0; t < 600; t++) begin
      @(posedge clk); #1;
      fin    = m_busy && (cyc == m_done);
      e.en   = m_busy;
      e.iack = fin && m_own_i;
      e.dack = fin && !m_own_i;
      e.we   = e.dack && m_we;
      e.ma   = m_addr;
      e.md   = m_wdata;
      e.ird  = e.iack ? mmem[m_addr[7:2]] : 32'h0;
      e.drd  = e.dack ? mmem[m_addr[7:2]] : 32'h0;
      if (d_act) begin
        if (e.dack) begin
          if ($urandom_range(0, 1) == 0) d_act = 1'b0;
          else begin dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom(); dm_wdata = $urandom(); end
        end else if ($urandom_range(0, 19) == 0) d_act = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_act = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom(); dm_wdata = $urandom();
      end
      if (i_act) begin
        if (e.iack) begin
          if ($urandom_range(0, 1) == 0) i_act = 1'b0;
          else if_addr = $urandom();
        end else if ($urandom_range(0, 19) == 0) i_act = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_act = 1'b1; if_addr = $urandom();
      end
      dm_req = d_act; if_req = i_act;
      e.ist = if_req && !e.iack;
      e.dst = dm_req && !e.dack;
      @(negedge clk);
      chk_out("rnd", e);
      if (e.we) mmem[m_addr[7:2]] = m_wdata;
      if (!m_busy || fin) begin
        pref_i = fin && !m_own_i;
        gi = if_req && (pref_i || !dm_req);
        gd = dm_req && !gi;
        m_busy = gi || gd;
        m_done = cyc + 1 + W;
        if (gd) begin m_own_i = 1'b0; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; end
        else if (gi) begin m_own_i = 1'b1; m_addr = if_addr; m_we = 1'b0; end
      end
`ifdef ARB_PERF_EN
      m_pi += 32'(e.ist);
      m_pd += 32'(e.dst);
`endif
      cyc++;
    end

`ifdef ARB_PERF_EN
    @(posedge clk); #1;
    chk("perf.if_cnt", if_stall_cnt, m_pi);
    chk("perf.dm_cnt", dm_stall_cnt, m_pd);
    drive(H, 32'h0, H, L, 32'h0, 32'h0);
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    drive(L, 32'h0, L, L, 32'h0, 32'h0);
    chk("perf.clr_if", if_stall_cnt, 32'h0);
    chk("perf.clr_dm", dm_stall_cnt, 32'h0);
`else
    @(posedge clk); #1;
    drive(L, 32'h0, L, L, 32'h0, 32'h0);
`endif
    repeat (2 * (W + 1) + 1) @(posedge clk);
    @(negedge clk);
    chk("end.idle", 32'(mem_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbiter/sequencer that shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Converts each requester's req/ack handshake into a multi-cycle memory access with a configurable number of wait states.
- Exports per-port stall signals that drive the pipeline's PC and IF/ID write enables.

Parameters:
- WAIT_STATES, 1: extra memory cycles per access; 0..15 legal. Each access spends WAIT_STATES+1 cycles in an access state.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held until if_ack
- if_addr  input  AW  fetch address
- if_rdata  output  DW  fetch data; valid only while if_ack=1
- if_ack  output  1  one-cycle completion pulse for the fetch
- if_stall  output  1  if_req & ~if_ack (combinational)
- dm_req  input  1  data request; held until dm_ack
- dm_we  input  1  1=store, 0=load
- dm_addr  input  AW  data address
- dm_wdata  input  DW  store data
- dm_rdata  output  DW  load data; valid only while dm_ack=1
- dm_ack  output  1  one-cycle completion pulse for the data access
- dm_stall  output  1  dm_req & ~dm_ack (combinational)
- mem_en  output  1  memory access active
- mem_we  output  1  memory write strobe
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, D_ACC, I_ACC. State, the owner latch and the 4-bit counter cnt are all registered.
- IDLE:
  - dm_req=1: latch dm_addr, dm_we and dm_wdata; cnt<=WAIT_STATES; next state D_ACC. The data port has priority because it serves the older instruction.
  - else if_req=1: latch if_addr; cnt<=WAIT_STATES; next state I_ACC.
  - else stay in IDLE.
- D_ACC / I_ACC:
  - mem_en=1; mem_addr and mem_wdata come from the latches and are stable for the whole access.
  - cnt decrements each cycle while cnt!=0.
- Final cycle (cnt==0):
  - Owner's ack=1 and owner's rdata=mem_rdata, both combinational.
  - D_ACC: mem_we = latched dm_we in this cycle only, so exactly one write per store.
- Next state after the final cycle:
  - Finished D_ACC: I_ACC if if_req, else D_ACC if dm_req, else IDLE.
  - Finished I_ACC: D_ACC if dm_req, else I_ACC if if_req, else IDLE.
  - The just-finished requester is serviced again only if the other port is idle.
  - Back-to-back accesses insert no IDLE cycle. The new access latches the new requester's inputs at that same edge.
- Re-request after ack: the requester updates its addr in the cycle after ack. A same-port re-grant latches at the ack edge, so the requester must present its next address in the ack cycle or deassert req. The IF stage complies because PC4 is already combinational.
- Latency: a request seen in IDLE at cycle 0 is acked in cycle WAIT_STATES+1.
  - Throughput under continuous dual requests: alternating grants, one ack per WAIT_STATES+1 cycles.
- Request dropped mid-access: the access is not aborted. It completes and the ack pulse is ignored.
- Outputs when not in the final cycle: ack=0, rdata=0. mem_we=0 outside the final D_ACC cycle.
- mem_addr and mem_wdata hold their last latched values in IDLE. mem_en=0 in IDLE.
- Reset (asynchronous, any state):
  - State=IDLE, cnt=0, latches=0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata.
  - An in-flight store is abandoned; no mem_we pulse occurs.
  - Stall outputs follow the req inputs after reset release.

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs if_stall_cnt (32) and dm_stall_cnt (32).
  - Each counter increments on every clock where its stall output is 1, and saturates at 32'hFFFFFFFF.
  - Cleared by reset. A synchronous clear input perf_clr (1) zeroes both counters the next edge; clear wins over increment.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- WAIT_STATES=2; if_req=1 with if_addr=0x40, mem returns 0x20080005 -> mem_en cycles 1-3; if_ack=1 and if_rdata=0x20080005 in cycle 3 only; if_stall=1 in cycles 0-2.
- if_req and dm_req both asserted in IDLE, dm_we=0, dm_addr=0x100 -> D served first (ack cycle 3), then I (ack cycle 6) with no IDLE gap; dm_stall=0 after cycle 3.
- Store: dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle (cycle 3) with mem_addr=0x10 and mem_wdata=0xDEADBEEF; a following load of 0x10 returns 0xDEADBEEF.
- Both ports requesting continuously for 12 cycles -> acks strictly alternate D,I,D,I; no port waits more than 2*(WAIT_STATES+1) cycles.
- Reset driven low in cycle 2 of a store -> all outputs 0 immediately, no mem_we pulse; after release with if_req=1, fetch acked WAIT_STATES+1 cycles later.
- ARB_PERF_EN, WAIT_STATES=0, 5 alternating dual-request accesses -> if_stall_cnt and dm_stall_cnt match a counted reference; perf_clr pulse zeroes both counters.
